// File: rtl/and_stim_pkg.sv
// Shared types and constants for the AND-gate stimulus generator.
// The vector table lists {a,b} per index; index 0 sits in the low bits.
package and_stim_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam int unsigned NUM_VECTORS = 4;
    localparam int unsigned IDX_W       = $clog2(NUM_VECTORS);
    localparam int unsigned ERR_W       = 3;

    typedef struct packed {
        logic a;
        logic b;
    } vec_t;

    localparam logic [2*NUM_VECTORS-1:0] VEC_TABLE = {2'b11, 2'b10, 2'b01, 2'b00};

    function automatic vec_t vec_lookup(input logic [IDX_W-1:0] idx);
        return vec_t'(VEC_TABLE[2*int'(idx) +: 2]);
    endfunction

endpackage

// File: rtl/step_timer.sv
// Per-vector hold counter: load, decrement toward zero, registered zero flag.
module step_timer #(
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             dec_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             zero_q;

    // Load wins over decrement; the count parks at zero rather than wrapping.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            zero_q  <= 1'b1;
        end else begin
            count_q <= count_d;
            zero_q  <= (count_d == '0);
        end
    end

    assign zero_o = zero_q;

endmodule

// File: rtl/and_stim_gen.sv
// Sweeps the four {a,b} vectors into a 2-input AND stage and checks its result.
// Define AND_STIM_CHECK_EN to enable result checking (err_cnt / pass).
module and_stim_gen
    import and_stim_pkg::*;
#(
    parameter int unsigned STEP_CYCLES = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       a,
    output logic       b,
    input  logic       dut_out,
    output logic [1:0] vec_idx,
    output logic       busy,
    output logic       done,
    output logic [2:0] err_cnt,
    output logic       pass
);

    localparam int unsigned      CNT_W    = $clog2(STEP_CYCLES + 1);
    localparam logic [CNT_W-1:0] RELOAD   = CNT_W'(STEP_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VECTORS - 1);

    state_e           state_q;
    logic             a_q;
    logic             b_q;
    logic             busy_q;
    logic             done_q;
    logic [IDX_W-1:0] idx_q;

    logic tmr_load_c;
    logic tmr_dec_c;
    logic tmr_zero;
    logic start_ok_c;
    logic last_vec_c;
    vec_t next_vec_c;

    // Timer control and next-vector lookup derived from the current state.
    always_comb begin
        start_ok_c = (state_q == ST_IDLE) && start;
        last_vec_c = (idx_q == LAST_IDX);
        tmr_load_c = start_ok_c || ((state_q == ST_SAMPLE) && !last_vec_c);
        tmr_dec_c  = (state_q == ST_DRIVE) && !tmr_zero;
        next_vec_c = vec_lookup(idx_q + IDX_W'(1));
    end

    step_timer #(
        .CNT_W (CNT_W)
    ) u_step_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load_c),
        .dec_i      (tmr_dec_c),
        .load_val_i (RELOAD),
        .zero_o     (tmr_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q    <= ST_DRIVE;
                        idx_q      <= '0;
                        {a_q, b_q} <= vec_lookup('0);
                        busy_q     <= 1'b1;
                    end
                end
                ST_DRIVE: begin
                    if (tmr_zero) begin
                        state_q <= ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    if (last_vec_c) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        state_q    <= ST_DRIVE;
                        idx_q      <= idx_q + IDX_W'(1);
                        {a_q, b_q} <= next_vec_c;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    idx_q   <= '0;
                    a_q     <= 1'b0;
                    b_q     <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef AND_STIM_CHECK_EN
    logic [ERR_W-1:0] err_q;
    logic             pass_q;
    logic             mismatch_c;

    assign mismatch_c = (dut_out != (a_q & b_q));

    // Result checking: counts mismatches, pass reflects the whole sweep including the final sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q  <= '0;
            pass_q <= 1'b0;
        end else if (start_ok_c) begin
            err_q  <= '0;
            pass_q <= 1'b0;
        end else if (state_q == ST_SAMPLE) begin
            if (mismatch_c) begin
                err_q <= err_q + ERR_W'(1);
            end
            if (last_vec_c) begin
                pass_q <= (err_q == '0) && !mismatch_c;
            end
        end
    end

    assign err_cnt = err_q;
    assign pass    = pass_q;
`else
    logic unused_dut_out;
    assign unused_dut_out = dut_out;
    assign err_cnt        = '0;
    assign pass           = 1'b0;
`endif

    assign a       = a_q;
    assign b       = b_q;
    assign vec_idx = idx_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_and_stim_gen.sv
// Scoreboard bench for and_stim_gen: two instances (STEP_CYCLES 5 and 1) share rst/start,
// each fed by an AND stage with a per-vector fault mask.
module tb_and_stim_gen;

    localparam int NI = 2;
`ifdef AND_STIM_CHECK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    typedef struct packed {
        logic       a;
        logic       b;
        logic [1:0] idx;
        logic       busy;
        logic       done;
        logic [2:0] err;
        logic       pass;
    } obs_t;

    typedef struct {
        int done_at;
        int err;
        bit pass;
    } done_exp_t;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       start = 1'b0;
    logic       a_w       [NI];
    logic       b_w       [NI];
    logic       dut_out_w [NI];
    logic       busy_w    [NI];
    logic       done_w    [NI];
    logic       pass_w    [NI];
    logic [1:0] idx_w     [NI];
    logic [2:0] err_w     [NI];
    logic [3:0] mask_m    [NI] = '{default: 4'h0};
    int         s_edge    [NI] = '{default: -1};

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    done_exp_t sb_q0[$];
    done_exp_t sb_q1[$];
    obs_t      mon_act;
    obs_t      mon_exp;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    and_stim_gen #(.STEP_CYCLES(5)) u_dut5 (
        .clk(clk), .rst(rst), .start(start), .a(a_w[0]), .b(b_w[0]), .dut_out(dut_out_w[0]),
        .vec_idx(idx_w[0]), .busy(busy_w[0]), .done(done_w[0]), .err_cnt(err_w[0]), .pass(pass_w[0])
    );

    and_stim_gen #(.STEP_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .a(a_w[1]), .b(b_w[1]), .dut_out(dut_out_w[1]),
        .vec_idx(idx_w[1]), .busy(busy_w[1]), .done(done_w[1]), .err_cnt(err_w[1]), .pass(pass_w[1])
    );

    // Downstream AND stage; a set mask bit corrupts the result for that vector.
    for (genvar gi = 0; gi < NI; gi++) begin : g_and
        assign dut_out_w[gi] = (a_w[gi] & b_w[gi]) ^ mask_m[gi][{a_w[gi], b_w[gi]}];
    end

    function automatic int step_of(input int i);
        return (i == 0) ? 5 : 1;
    endfunction

    function automatic bit model_idle(input int i, input int e);
        return (s_edge[i] < 0) || (e >= s_edge[i] + 4 * (step_of(i) + 1) + 2);
    endfunction

    // Expected outputs after edge e, from the sweep timeline of the last accepted start.
    function automatic obs_t model(input int i, input int e);
        obs_t o;
        int   per;
        int   t;
        int   errs;
        o    = '0;
        per  = step_of(i) + 1;
        errs = 0;
        if (s_edge[i] < 0) return o;
        t = e - s_edge[i];
        if (t < 4 * per) begin
            o.idx  = 2'(t / per);
            o.a    = o.idx[1];
            o.b    = o.idx[0];
            o.busy = 1'b1;
        end else if (t == 4 * per) begin
            o.idx  = 2'd3;
            o.a    = 1'b1;
            o.b    = 1'b1;
            o.done = 1'b1;
        end
        for (int v = 0; v < 4; v++) begin
            if (mask_m[i][v] && (t >= (v + 1) * per)) errs++;
        end
        if (CHK_EN) begin
            o.err  = 3'(errs);
            o.pass = (t >= 4 * per) && (errs == 0);
        end
        return o;
    endfunction

    task automatic pop_check(input int i);
        done_exp_t d;
        bit        have;
        have = (i == 0) ? (sb_q0.size() > 0) : (sb_q1.size() > 0);
        checks++;
        if (!have) begin
            errors++;
            $display("FAIL done_unexpected inst%0d edge %0d: got done=1, required no pending sweep", i, cyc);
            return;
        end
        if (i == 0) d = sb_q0.pop_front();
        else        d = sb_q1.pop_front();
        if ((cyc != d.done_at) || (err_w[i] !== 3'(d.err)) || (pass_w[i] !== d.pass)) begin
            errors++;
            $display("FAIL done_result inst%0d: got edge %0d err %0d pass %0b, required edge %0d err %0d pass %0b",
                     i, cyc, err_w[i], pass_w[i], d.done_at, d.err, d.pass);
        end
    endtask

    // Monitor: compares every cycle and pops the scoreboard on each done pulse.
    always @(posedge clk) begin
        #3;
        for (int i = 0; i < NI; i++) begin
            mon_act = {a_w[i], b_w[i], idx_w[i], busy_w[i], done_w[i], err_w[i], pass_w[i]};
            mon_exp = model(i, cyc);
            checks++;
            if (mon_act !== mon_exp) begin
                errors++;
                $display("FAIL outputs inst%0d edge %0d: got {a,b,idx,busy,done,err,pass}=%h, required %h",
                         i, cyc, mon_act, mon_exp);
            end
            if (mon_act.done === 1'b1) pop_check(i);
        end
    end

    // Drives rst/start for the next edge and records the expected sweep outcome.
    task automatic step(input logic r, input logic st, input logic [3:0] m);
        int e;
        e     = cyc + 1;
        rst   = r;
        start = st;
        for (int i = 0; i < NI; i++) begin
            if (r) begin
                s_edge[i] = -1;
                if (i == 0) sb_q0.delete();
                else        sb_q1.delete();
            end else if (st && model_idle(i, e)) begin
                done_exp_t d;
                s_edge[i] = e;
                mask_m[i] = m;
                d.done_at = e + 4 * (step_of(i) + 1);
                d.err     = CHK_EN ? $countones(m) : 0;
                d.pass    = CHK_EN && (m == 4'h0);
                if (i == 0) sb_q0.push_back(d);
                else        sb_q1.push_back(d);
            end
        end
        @(negedge clk);
    endtask

    task automatic idle_n(input int n);
        repeat (n) step(1'b0, 1'b0, 4'h0);
    endtask

    initial begin
        logic       r;
        logic       st;
        logic [3:0] m;
        @(negedge clk);
        repeat (3) step(1'b1, 1'b0, 4'h0);
        // Clean sweep with an ideal AND stage.
        step(1'b0, 1'b1, 4'h0);
        idle_n(30);
        // Output stuck at 1: vectors 0..2 mismatch.
        step(1'b0, 1'b1, 4'b0111);
        idle_n(30);
        // Reset while vector 2 is driven, then a clean sweep.
        step(1'b0, 1'b1, 4'b0110);
        idle_n(13);
        step(1'b1, 1'b1, 4'h0);
        idle_n(3);
        step(1'b0, 1'b1, 4'h0);
        idle_n(30);
        // Extra starts mid-sweep and during DONE, then a restart from IDLE.
        step(1'b0, 1'b1, 4'b1000);
        idle_n(6);
        step(1'b0, 1'b1, 4'hF);
        idle_n(17);
        step(1'b0, 1'b1, 4'hF);
        idle_n(30);
        step(1'b0, 1'b1, 4'h0);
        idle_n(30);
        // Randomized traffic.
        repeat (300) begin
            r  = ($urandom_range(0, 49) == 0);
            st = ($urandom_range(0, 5) == 0);
            m  = 4'($urandom);
            step(r, st, m);
        end
        idle_n(30);
        checks++;
        if ((sb_q0.size() + sb_q1.size()) != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending sweeps, required 0", sb_q0.size() + sb_q1.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/and_stim_gen.md
AND_STIM_GEN -- requirements
Module: and_stim_gen

Interface
REQ-001 Parameter: STEP_CYCLES, default 5, number of clock cycles each input vector is held before sampling; legal range 1..255.
REQ-002 Port: clk  input  1  single clock; all logic on rising edge.
REQ-003 Port: rst  input  1  reset is synchronous and active-high.
REQ-004 Port: start  input  1  request one full sweep; sampled only in IDLE.
REQ-005 Port: a  output  1  first operand driven to the downstream 2-input AND stage.
REQ-006 Port: b  output  1  second operand driven to the downstream 2-input AND stage.
REQ-007 Port: dut_out  input  1  result returned from the AND stage.
REQ-008 Port: vec_idx  output  2  index of the vector currently driven (0..3).
REQ-009 Port: busy  output  1  high in DRIVE and SAMPLE states.
REQ-010 Port: done  output  1  one-cycle pulse at sweep completion.
REQ-011 Port: err_cnt  output  3  mismatches in the last or current sweep (0..4).
REQ-012 Port: pass  output  1  high when the last completed sweep had err_cnt==0; held until next start.

Function
REQ-013 FSM states: IDLE, DRIVE, SAMPLE, DONE.
REQ-014 Vector table, in order: idx0 a=0,b=0; idx1 a=0,b=1; idx2 a=1,b=0; idx3 a=1,b=1.
REQ-015 IDLE & start=1: go DRIVE; vec_idx<=0; a,b<=vector 0; step counter<=STEP_CYCLES-1; err_cnt<=0; pass<=0.
REQ-016 DRIVE: counter decrements each cycle; at counter==0 go SAMPLE; a,b held stable.
REQ-017 SAMPLE (one cycle): compare dut_out against a&b; on mismatch err_cnt increments.
REQ-018 SAMPLE & vec_idx<3: vec_idx increments, next vector driven, counter reloaded to STEP_CYCLES-1, go DRIVE.
REQ-019 SAMPLE & vec_idx==3: go DONE; pass<=(final err_cnt==0).
REQ-020 DONE: done=1 for exactly one cycle, then IDLE; a,b return to 0 in IDLE.
REQ-021 Latency: done high in the cycle beginning 4*(STEP_CYCLES+1) edges after the edge that sampled start (24 for default).
REQ-022 start while busy or in DONE is ignored; no queuing.
REQ-023 Counter width: $clog2(STEP_CYCLES+1) bits minimum; no wrap permitted.
REQ-024 err_cnt never exceeds 4; no saturation logic required.

Reset
REQ-025 rst=1 at any cycle, including mid-sweep, forces IDLE next edge: a=0, b=0, vec_idx=0, busy=0, done=0, err_cnt=0, pass=0, counter=0.
REQ-026 start asserted in the same cycle as rst is ignored.

Configuration
REQ-027 Macro AND_STIM_CHECK_EN: defined -> comparison logic, err_cnt and pass behave per REQ-017/019.
REQ-028 Macro undefined -> dut_out ignored, err_cnt constant 0, pass constant 0; sequencing and timing unchanged.

Structure
REQ-029 Package and_stim_pkg holds the state enum, NUM_VECTORS=4, and the vector table constant.
REQ-030 One sub-module step_timer (load, decrement, zero flag) implements the per-vector hold counter.

Verification
REQ-031 rst, then start pulse, ideal AND model on dut_out -> a/b sequence 00,01,10,11 each held 5 cycles + 1 sample cycle; done at edge 24; err_cnt=0, pass=1.
REQ-032 dut_out stuck at 1 -> err_cnt=3, pass=0 at done.
REQ-033 STEP_CYCLES=1 -> done at edge 8; every vector held exactly 2 cycles.
REQ-034 rst asserted during vec_idx=2 -> next cycle IDLE, all outputs 0; subsequent start runs a full clean sweep.
REQ-035 start pulsed again at vec_idx=1 and during DONE -> ignored; single done pulse; a second start in IDLE restarts with err_cnt cleared.
REQ-036 Build without AND_STIM_CHECK_EN, dut_out stuck at 1 -> identical a/b/done timing, err_cnt=0, pass=0.
